// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one unsigned magnitude comparator
module cmp_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [IDW-1:0]        res_id,
   output logic                  res_gt,
   output logic                  res_eq,
   output logic                  res_lt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

   logic [1:0]        state;
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    id_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              found;
   logic [IDW-1:0]    off;
   logic [IDW:0]      sum;
   logic [IDW:0]      sum_wrap;
   logic [IDW-1:0]    winner;
   logic [IDW-1:0]    ptr_next;
   logic [WIDTH-1:0]  a_sel;
   logic [WIDTH-1:0]  b_sel;

   // Rotate so that bit 0 is the requester at ptr; the first set bit is the winner's offset.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: NREQ];

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            off   = IDW'(k);
         end
      end
   end

   assign sum      = {1'b0, ptr} + {1'b0, off};
   assign sum_wrap = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
   assign winner   = sum_wrap[IDW-1:0];
   assign ptr_next = (winner == LAST) ? '0 : (winner + 1'b1);

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (winner == IDW'(k)) begin
            a_sel = a_in[k*WIDTH +: WIDTH];
            b_sel = b_in[k*WIDTH +: WIDTH];
         end
      end
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         gnt       <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_gt    <= 1'b0;
         res_eq    <= 1'b0;
         res_lt    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               gnt <= '0;
               if (found) begin
                  a_q   <= a_sel;
                  b_q   <= b_sel;
                  id_q  <= winner;
                  gnt   <= NREQ'(1) << winner;
                  ptr   <= ptr_next;
                  state <= ST_CMP;
               end
            end
            ST_CMP: begin
               gnt       <= '0;
               res_gt    <= (a_q > b_q);
               res_eq    <= (a_q == b_q);
               res_lt    <= (a_q < b_q);
               res_id    <= id_q;
               res_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               gnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - randomized bench for cmp_arbiter against a transaction-level model
module tb_cmp_arbiter;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  res_valid;
   logic                  res_ready;
   logic [IDW-1:0]        res_id;
   logic                  res_gt;
   logic                  res_eq;
   logic                  res_lt;

   always #5 clk = ~clk;

   cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_gt    (res_gt),
      .res_eq    (res_eq),
      .res_lt    (res_lt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 = free, 1 = granted, 2 = result offered.
   int m_phase, m_ptr, m_gnt, m_valid, m_id, m_gt, m_eq, m_lt, m_a, m_b, m_owner;
   int cyc;
   int gq[$];
   int gcyc[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick(input int start, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++)
         if (r[(start + k) % NREQ]) return (start + k) % NREQ;
      return -1;
   endfunction

   task automatic model_edge();
      int w;
      if (rst) begin
         m_phase = 0; m_ptr = 0; m_gnt = 0; m_valid = 0; m_id = 0;
         m_gt = 0; m_eq = 0; m_lt = 0; m_a = 0; m_b = 0; m_owner = 0;
      end else if (m_phase == 0) begin
         m_gnt = 0;
         w = pick(m_ptr, req);
         if (w >= 0) begin
            m_a     = int'(a_in[w*WIDTH +: WIDTH]);
            m_b     = int'(b_in[w*WIDTH +: WIDTH]);
            m_owner = w;
            m_gnt   = 1 << w;
            m_ptr   = (w + 1) % NREQ;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_gnt   = 0;
         m_gt    = (m_a > m_b)  ? 1 : 0;
         m_eq    = (m_a == m_b) ? 1 : 0;
         m_lt    = (m_a < m_b)  ? 1 : 0;
         m_id    = m_owner;
         m_valid = 1;
         m_phase = 2;
      end else if (res_ready) begin
         m_valid = 0;
         m_phase = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      check("gnt", 32'(gnt), m_gnt);
      check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
      check("res_valid", 32'(res_valid), m_valid);
      check("res_id", 32'(res_id), m_id);
      check("res_gt", 32'(res_gt), m_gt);
      check("res_eq", 32'(res_eq), m_eq);
      check("res_lt", 32'(res_lt), m_lt);
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) begin
            gq.push_back(i);
            gcyc.push_back(cyc);
         end
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
      b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
   endtask

   task automatic drain();
      req = '0;
      res_ready = 1'b1;
      for (int i = 0; i < 10 && busy; i++) cycle();
      check("drain_busy", 32'(busy), 0);
   endtask

   initial begin
      cyc = 0;
      rst = 1'b1; req = '1; a_in = '0; b_in = '0; res_ready = 1'b0;

      // Reset with all requests asserted
      cycle(); cycle();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0; req = '0;
      cycle();

      // Single request, A < B
      req = 4'b0001; set_ops(0, 3, 12); res_ready = 1'b1;
      cycle();
      check("single_gnt", 32'(gnt), 32'h1);
      req = '0;
      cycle();
      check("single_valid", 32'(res_valid), 1);
      check("single_lt", 32'({res_gt, res_eq, res_lt}), 32'h1);
      check("single_id", 32'(res_id), 0);
      cycle();
      check("single_idle", 32'(busy), 0);

      // Round-robin from a fresh pointer
      rst = 1'b1; cycle(); rst = 1'b0;
      gq.delete(); gcyc.delete();
      req = '1;
      for (int i = 0; i < NREQ; i++) set_ops(i, 5, 5);
      for (int i = 0; i < 15; i++) cycle();
      check("rr_count", 32'(gq.size()), 5);
      for (int i = 0; i < 5 && i < gq.size(); i++) begin
         check("rr_order", 32'(gq[i]), i % NREQ);
         if (i > 0) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
      end
      drain();

      // Backpressure: result held, no new grant
      req = 4'b0100; set_ops(2, 15, 0); res_ready = 1'b0;
      cycle();
      check("bp_gnt", 32'(gnt), 32'h4);
      for (int i = 0; i < 6; i++) cycle();
      check("bp_hold", 32'({res_valid, res_id, res_gt}), 32'b1101);
      res_ready = 1'b1; req = '0;
      cycle();
      check("bp_accept", 32'(res_valid), 0);

      // Operand change after grant is not seen
      req = 4'b0010; set_ops(1, 9, 9);
      cycle();
      check("chg_gnt", 32'(gnt), 32'h2);
      set_ops(1, 1, 9); req = '0;
      cycle();
      check("chg_eq", 32'(res_eq), 1);
      cycle();

      // Reset while comparing
      req = '1;
      cycle();
      rst = 1'b1; req = '0;
      cycle();
      check("midrst_valid", 32'(res_valid), 0);
      rst = 1'b0; req = '1;
      cycle();
      check("midrst_gnt", 32'(gnt), 32'h1);
      drain();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         req = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            int a;
            a = $urandom_range(0, (1 << WIDTH) - 1);
            set_ops(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, (1 << WIDTH) - 1));
         end
         res_ready = ($urandom_range(0, 1) == 1);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
